// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit Harvard core: widths, instruction fields,
// opcodes and the per-opcode operand/writeback classification.
package core_pkg;

   localparam int REG_W = 16;
   localparam int NREG  = 32;
   localparam int RA_W  = $clog2(NREG);
   localparam int IMM_W = 7;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 7;
   localparam int RS_MSB  = 6;
   localparam int RS_LSB  = 2;
   localparam int IMM_MSB = 6;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SHL  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_MOV  = 4'd7;
   localparam logic [3:0] OP_ADDI = 4'd8;
   localparam logic [3:0] OP_LDI  = 4'd9;
   localparam logic [3:0] OP_LD   = 4'd10;
   localparam logic [3:0] OP_ST   = 4'd11;
   localparam logic [3:0] OP_BEQ  = 4'd12;
   localparam logic [3:0] OP_JMP  = 4'd13;
   localparam logic [3:0] OP_NOP  = 4'd14;
   localparam logic [3:0] OP_HALT = 4'd15;

   typedef enum logic {ST_RUN, ST_HALTED} state_t;

   typedef struct packed {
      logic read_rd;
      logic read_rs;
      logic write_rd;
      logic imm_sext;
      logic imm_zext;
   } dec_t;

   // Which register fields an opcode reads or writes, and whether operand B is an immediate.
   function automatic dec_t decode_op(input logic [3:0] op);
      dec_t d;
      d = '0;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            d.read_rd  = 1'b1;
            d.read_rs  = 1'b1;
            d.write_rd = 1'b1;
         end
         OP_MOV, OP_LD: begin
            d.read_rs  = 1'b1;
            d.write_rd = 1'b1;
         end
         OP_ADDI: begin
            d.read_rd  = 1'b1;
            d.write_rd = 1'b1;
            d.imm_sext = 1'b1;
         end
         OP_LDI: begin
            d.write_rd = 1'b1;
            d.imm_zext = 1'b1;
         end
         OP_ST, OP_BEQ: begin
            d.read_rd = 1'b1;
            d.read_rs = 1'b1;
         end
         OP_JMP: d.read_rs = 1'b1;
         OP_NOP, OP_HALT: d = '0;
         default: d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue of a
// writing instruction and cleared by writeback, with three combinational lookups.
module hazard_scoreboard
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_en,
   input  logic [RA_W-1:0] set_addr,
   input  logic            clr_en,
   input  logic [RA_W-1:0] clr_addr,
   input  logic [RA_W-1:0] look_a,
   input  logic [RA_W-1:0] look_b,
   input  logic [RA_W-1:0] look_c,
   output logic            pend_a,
   output logic            pend_b,
   output logic            pend_c
);

   logic [NREG-1:0] pending;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;

   // r0 is hardwired, so it is never tracked in either direction.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && set_addr != '0) set_mask[set_addr] = 1'b1;
      if (clr_en && clr_addr != '0) clr_mask[clr_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) pending <= '0;
      else        pending <= (pending & ~clr_mask) | set_mask;
   end

   assign pend_a = pending[look_a];
   assign pend_b = pending[look_b];
   assign pend_c = pending[look_c];

endmodule

// File: rtl/decode_stage.sv
// Decode and operand-fetch stage: decodes the fetched word, reads both operands,
// stalls on scoreboard hazards and holds one payload for execute.
module decode_stage
   import core_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   input  logic [REG_W-1:0] if_instr,
   output logic             if_ready,
   output logic [RA_W-1:0]  rf_raddr_a,
   output logic [RA_W-1:0]  rf_raddr_b,
   input  logic [REG_W-1:0] rf_rdata_a,
   input  logic [REG_W-1:0] rf_rdata_b,
   output logic             ex_valid,
   input  logic             ex_ready,
   output logic [3:0]       ex_op,
   output logic [RA_W-1:0]  ex_rd,
   output logic [REG_W-1:0] ex_a,
   output logic [REG_W-1:0] ex_b,
   output logic             ex_we,
   input  logic             wb_valid,
   input  logic [RA_W-1:0]  wb_addr,
   output logic             halted
);

   logic [3:0]       op;
   logic [RA_W-1:0]  rd;
   logic [RA_W-1:0]  rs;
   logic [IMM_W-1:0] imm7;
   dec_t             dec;
   logic             pend_rd;
   logic             pend_rs;
   logic             pend_dst;
   logic             hazard;
   logic             slot_free;
   logic             issue;
   logic [REG_W-1:0] a_next;
   logic [REG_W-1:0] b_next;
   state_t           state;
   state_t           state_next;

   assign op   = if_instr[OP_MSB:OP_LSB];
   assign rd   = if_instr[RD_MSB:RD_LSB];
   assign rs   = if_instr[RS_MSB:RS_LSB];
   assign imm7 = if_instr[IMM_MSB:IMM_LSB];
   assign dec  = decode_op(op);

   assign rf_raddr_a = rd;
   assign rf_raddr_b = rs;

   hazard_scoreboard u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue && dec.write_rd),
      .set_addr (rd),
      .clr_en   (wb_valid),
      .clr_addr (wb_addr),
      .look_a   (rd),
      .look_b   (rs),
      .look_c   (rd),
      .pend_a   (pend_rd),
      .pend_b   (pend_rs),
      .pend_c   (pend_dst)
   );

   assign hazard    = (dec.read_rd && pend_rd) || (dec.read_rs && pend_rs) ||
                      (dec.write_rd && pend_dst);
   assign slot_free = !ex_valid || ex_ready;
   assign halted    = (state == ST_HALTED);
   assign if_ready  = slot_free && !hazard && !halted;
   assign issue     = if_valid && if_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_next;
   end

   // HALT is still handed to execute; only later fetches are refused.
   always_comb begin
      state_next = state;
      if (state == ST_RUN && issue && op == OP_HALT) state_next = ST_HALTED;
   end

   // Operands that the opcode does not read are forced to zero.
   always_comb begin
      a_next = '0;
      b_next = '0;
      if (dec.read_rd) a_next = rf_rdata_a;
      if (dec.imm_sext)     b_next = {{(REG_W-IMM_W){imm7[IMM_W-1]}}, imm7};
      else if (dec.imm_zext) b_next = {{(REG_W-IMM_W){1'b0}}, imm7};
      else if (dec.read_rs)  b_next = rf_rdata_b;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_op    <= '0;
         ex_rd    <= '0;
         ex_a     <= '0;
         ex_b     <= '0;
         ex_we    <= 1'b0;
      end else if (issue) begin
         ex_valid <= 1'b1;
         ex_op    <= op;
         ex_rd    <= rd;
         ex_a     <= a_next;
         ex_b     <= b_next;
         ex_we    <= dec.write_rd;
      end else if (ex_ready) begin
         ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus random traffic, all checked
// against an instruction-level model of issue, operands and pending writes.
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        if_valid;
   logic [15:0] if_instr;
   logic        if_ready;
   logic [4:0]  rf_raddr_a;
   logic [4:0]  rf_raddr_b;
   logic [15:0] rf_rdata_a;
   logic [15:0] rf_rdata_b;
   logic        ex_valid;
   logic        ex_ready;
   logic [3:0]  ex_op;
   logic [4:0]  ex_rd;
   logic [15:0] ex_a;
   logic [15:0] ex_b;
   logic        ex_we;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic        halted;

   logic [15:0] rf [32];

   int checkCount = 0;
   int failCount  = 0;

   bit          mValid;
   logic [3:0]  mOp;
   logic [4:0]  mRd;
   logic [15:0] mA;
   logic [15:0] mB;
   bit          mWe;
   bit          mPend [32];
   bit          mHalted;
   bit          obsReady;

   decode_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .if_valid   (if_valid),
      .if_instr   (if_instr),
      .if_ready   (if_ready),
      .rf_raddr_a (rf_raddr_a),
      .rf_raddr_b (rf_raddr_b),
      .rf_rdata_a (rf_rdata_a),
      .rf_rdata_b (rf_rdata_b),
      .ex_valid   (ex_valid),
      .ex_ready   (ex_ready),
      .ex_op      (ex_op),
      .ex_rd      (ex_rd),
      .ex_a       (ex_a),
      .ex_b       (ex_b),
      .ex_we      (ex_we),
      .wb_valid   (wb_valid),
      .wb_addr    (wb_addr),
      .halted     (halted)
   );

   assign rf_rdata_a = rf[rf_raddr_a];
   assign rf_rdata_b = rf[rf_raddr_b];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Register usage of each opcode, stated as opcode ranges.
   function automatic void semantics(input logic [3:0] op, output bit rdRead,
                                     output bit rsRead, output bit writes);
      rdRead = (op <= 4'd6) || op == 4'd8 || op == 4'd11 || op == 4'd12;
      rsRead = (op <= 4'd7) || op == 4'd10 || op == 4'd11 || op == 4'd12 || op == 4'd13;
      writes = (op <= 4'd10);
   endfunction

   function automatic logic [15:0] mkReg(input int op, input int rd, input int rs);
      return {op[3:0], rd[4:0], rs[4:0], 2'b00};
   endfunction

   function automatic logic [15:0] mkImm(input int op, input int rd, input int imm);
      return {op[3:0], rd[4:0], imm[6:0]};
   endfunction

   task automatic modelReset();
      mValid  = 1'b0;
      mOp     = '0;
      mRd     = '0;
      mA      = '0;
      mB      = '0;
      mWe     = 1'b0;
      mHalted = 1'b0;
      for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
   endtask

   task automatic doReset();
      rst_n    = 1'b0;
      if_valid = 1'b0;
      ex_ready = 1'b0;
      wb_valid = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      modelReset();
      checkOutput("rst_ex_valid", ex_valid, 0);
      checkOutput("rst_ex_op", ex_op, 0);
      checkOutput("rst_ex_rd", ex_rd, 0);
      checkOutput("rst_ex_a", ex_a, 0);
      checkOutput("rst_ex_b", ex_b, 0);
      checkOutput("rst_ex_we", ex_we, 0);
      checkOutput("rst_halted", halted, 0);
   endtask

   // One clock of stimulus; compares every output with the model, then advances it.
   task automatic applyStimulus(input bit v, input logic [15:0] instr, input bit rdy,
                                input bit wbv, input logic [4:0] wba);
      bit          rdR, rsR, wr, hz, expReady, issue;
      logic [3:0]  op;
      logic [4:0]  rd, rs;
      logic [15:0] a, b;
      int          s;
      if_valid = v;
      if_instr = instr;
      ex_ready = rdy;
      wb_valid = wbv;
      wb_addr  = wba;
      #4;
      op = instr[15:12];
      rd = instr[11:7];
      rs = instr[6:2];
      semantics(op, rdR, rsR, wr);
      hz = (rdR && mPend[rd]) || (rsR && mPend[rs]) || (wr && mPend[rd]);
      expReady = !mHalted && (!mValid || rdy) && !hz;
      obsReady = if_ready;
      checkOutput("if_ready", if_ready, expReady);
      checkOutput("rf_raddr_a", rf_raddr_a, rd);
      checkOutput("rf_raddr_b", rf_raddr_b, rs);
      checkOutput("ex_valid", ex_valid, mValid);
      checkOutput("halted", halted, mHalted);
      if (mValid) begin
         checkOutput("ex_op", ex_op, mOp);
         checkOutput("ex_rd", ex_rd, mRd);
         checkOutput("ex_a", ex_a, mA);
         checkOutput("ex_b", ex_b, mB);
         checkOutput("ex_we", ex_we, mWe);
      end
      a = rdR ? rf[rd] : 16'd0;
      s = int'(instr[6:0]);
      if (op == 4'd8) begin
         if (s >= 64) s = s - 128;
         b = 16'(s);
      end else if (op == 4'd9) b = 16'(s);
      else if (rsR)            b = rf[rs];
      else                     b = 16'd0;
      issue = v && expReady;
      @(posedge clk);
      #1;
      if (wbv && wba != 0) mPend[wba] = 1'b0;
      if (issue) begin
         mValid = 1'b1;
         mOp    = op;
         mRd    = rd;
         mA     = a;
         mB     = b;
         mWe    = wr;
         if (wr && rd != 0) mPend[rd] = 1'b1;
         if (op == 4'd15)   mHalted   = 1'b1;
      end else if (rdy) begin
         mValid = 1'b0;
      end
   endtask

   initial begin
      logic [15:0] nop, instr;
      int          op;
      bit          wbv;
      logic [4:0]  wba;
      nop      = mkReg(14, 0, 0);
      rst_n    = 1'b0;
      if_valid = 1'b0;
      if_instr = '0;
      ex_ready = 1'b0;
      wb_valid = 1'b0;
      wb_addr  = '0;
      for (int i = 0; i < 32; i++) rf[i] = 16'(i * 16'h0101);
      doReset();

      // Back-to-back issue
      rf[3] = 16'd3;
      rf[4] = 16'd4;
      applyStimulus(1, mkReg(0, 3, 4), 1, 0, 0);
      checkOutput("b2b_add_valid", ex_valid, 1);
      checkOutput("b2b_add_a", ex_a, 16'd3);
      checkOutput("b2b_add_b", ex_b, 16'd4);
      checkOutput("b2b_add_we", ex_we, 1);
      applyStimulus(1, mkImm(9, 5, 'h7F), 1, 0, 0);
      checkOutput("b2b_ldi_valid", ex_valid, 1);
      checkOutput("b2b_ldi_b", ex_b, 16'h007F);
      applyStimulus(0, nop, 1, 1, 5'd3);
      applyStimulus(0, nop, 1, 1, 5'd5);

      // RAW stall
      rf[2] = 16'd10;
      applyStimulus(1, mkImm(8, 2, 'h7F), 1, 0, 0);
      checkOutput("raw_addi_b", ex_b, 16'hFFFF);
      checkOutput("raw_addi_a", ex_a, 16'd10);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, mkReg(7, 6, 2), 1, 0, 0);
         checkOutput("raw_stall", obsReady, 0);
      end
      applyStimulus(1, mkReg(7, 6, 2), 1, 1, 5'd2);
      checkOutput("raw_wb_edge", obsReady, 0);
      applyStimulus(1, mkReg(7, 6, 2), 1, 0, 0);
      checkOutput("raw_issue", obsReady, 1);
      checkOutput("raw_mov_op", ex_op, 4'd7);
      applyStimulus(0, nop, 1, 1, 5'd6);

      // WAW and r0
      applyStimulus(1, mkImm(9, 1, 5), 1, 0, 0);
      applyStimulus(1, mkImm(9, 1, 6), 1, 0, 0);
      checkOutput("waw_stall", obsReady, 0);
      applyStimulus(1, mkImm(9, 1, 6), 1, 1, 5'd1);
      checkOutput("waw_wb_edge", obsReady, 0);
      applyStimulus(1, mkImm(9, 1, 6), 1, 0, 0);
      checkOutput("waw_issue", obsReady, 1);
      applyStimulus(0, nop, 1, 1, 5'd1);
      applyStimulus(1, mkImm(9, 0, 5), 1, 0, 0);
      checkOutput("r0_first", obsReady, 1);
      applyStimulus(1, mkImm(9, 0, 5), 1, 0, 0);
      checkOutput("r0_second", obsReady, 1);

      // Back-pressure
      applyStimulus(1, mkImm(9, 7, 'h12), 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, nop, 0, 0, 0);
         checkOutput("bp_ready", obsReady, 0);
         checkOutput("bp_hold_b", ex_b, 16'h0012);
      end
      applyStimulus(0, nop, 1, 0, 0);
      checkOutput("bp_consumed", ex_valid, 0);
      applyStimulus(0, nop, 1, 1, 5'd7);

      // HALT then reset
      applyStimulus(1, mkImm(9, 4, 1), 1, 0, 0);
      applyStimulus(1, mkReg(15, 0, 0), 1, 0, 0);
      checkOutput("halt_flag", halted, 1);
      checkOutput("halt_forwarded", ex_op, 4'd15);
      applyStimulus(1, nop, 1, 0, 0);
      checkOutput("halt_nop_refused", obsReady, 0);
      doReset();
      applyStimulus(1, nop, 1, 1, 5'd4);
      checkOutput("post_rst_nop", obsReady, 1);
      applyStimulus(1, mkReg(0, 4, 4), 1, 0, 0);
      checkOutput("post_rst_sb_empty", obsReady, 1);

      // Random traffic on a small register window so hazards are frequent
      for (int c = 0; c < 600; c++) begin
         rf[$urandom_range(0, 31)] = 16'($urandom);
         if (mHalted && $urandom_range(0, 5) == 0) begin
            doReset();
         end else begin
            op    = ($urandom_range(0, 59) == 0) ? 15 : int'($urandom_range(0, 14));
            instr = {op[3:0], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom)};
            wba   = 5'($urandom_range(0, 7));
            wbv   = ($urandom_range(0, 2) == 0) && (mPend[wba] || wba == 0);
            applyStimulus($urandom_range(0, 3) != 0, instr, $urandom_range(0, 9) < 7, wbv, wba);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode and operand-fetch stage of the 16-bit Harvard core. It sits between instruction fetch and execute and drives the read addresses of the 32×16 register file. It decodes each 16-bit instruction and captures both operands into a single pipeline register. A 32-entry pending-write scoreboard, cleared by writeback, stalls issue on RAW and WAW hazards.

## Interface
- REG_W, 16: datapath and instruction width.
- NREG, 32: architectural registers; address width is clog2(NREG) = 5.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, synchronous, active-low.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  16  instruction word.
- if_ready  out  1  decode accepts if_instr this cycle.
- rf_raddr_a  out  5  register-file read address A; always instr[11:7].
- rf_raddr_b  out  5  register-file read address B; always instr[6:2].
- rf_rdata_a  in  16  combinational read data A.
- rf_rdata_b  in  16  combinational read data B.
- ex_valid  out  1  execute payload valid.
- ex_ready  in  1  execute consumes the payload.
- ex_op  out  4  opcode.
- ex_rd  out  5  destination or first-source register.
- ex_a  out  16  operand A.
- ex_b  out  16  operand B or extended immediate.
- ex_we  out  1  instruction writes ex_rd.
- wb_valid  in  1  writeback retires a register write.
- wb_addr  in  5  register retired.
- halted  out  1  HALT has been issued.

## Operation
- Field layout: op = [15:12], rd = [11:7], rs = [6:2], imm7 = [6:0].
- ALU ops ADD, SUB, AND, OR, XOR, SHL, SHR (0–6): rd = rd op rs. These read rd and rs and write rd.
- MOV (7): rd = rs. Reads rs, writes rd.
- ADDI (8): reads rd, writes rd. ex_b = sign-extended imm7.
- LDI (9): reads nothing, writes rd. ex_b = zero-extended imm7.
- LD (10): reads rs, writes rd.
- ST (11): reads rd and rs, no write.
- BEQ (12): reads rd and rs, no write.
- JMP (13): reads rs, no write.
- NOP (14): no reads, no write.
- HALT (15): no reads, no write.
- Operand routing: ex_a = rf_rdata_a and ex_b = rf_rdata_b, except for the immediate forms above. Operands that are not read are driven to 0.
- Scoreboard: a 32-bit pending vector.
  - Bit rd is set when an instruction with ex_we = 1 issues.
  - Bit wb_addr is cleared when wb_valid = 1.
  - r0 is never set; wb_addr = 0 is ignored.
- Hazard: stall when any register the instruction reads is pending, or when the instruction writes rd and rd is pending.
- Slot free: !ex_valid || ex_ready.
- if_ready = slot_free && !hazard && !halted. Issue occurs when if_valid && if_ready.
- States:
  - RUN → HALTED when HALT issues. HALT itself is forwarded to execute.
  - HALTED: if_ready = 0 and the scoreboard keeps updating. It exits only via reset.

## Timing
- Reset values: ex_valid 0; ex_op, ex_rd, ex_a, ex_b, ex_we all 0; scoreboard all 0; halted 0.
- Latency: an instruction accepted at edge N has ex_valid = 1 in the cycle after N. Operand data is the register-file contents sampled at edge N.
- Throughput: one instruction per cycle with no hazards and ex_ready held at 1.
- Back-pressure: while ex_valid && !ex_ready, all ex_* outputs hold stable and if_ready = 0.
- Hazard check uses the registered scoreboard. A wb clear at edge N unblocks issue in the cycle after N, so there is one bubble minimum after writeback.
- Set and clear of different bits at the same edge both take effect.
- Set and clear of the same bit at the same edge cannot occur, because WAW stalls the issue.
- ex_valid falls after an accepted payload if no new issue occurs in that cycle.
- Reset mid-stream drops the held payload and clears the scoreboard. Writebacks of already-issued instructions arriving after reset are harmless clears.

## Structure
- Package core_pkg holds:
  - opcode constants OP_ADD … OP_HALT;
  - field position constants;
  - REG_W and NREG.
- One sub-module, hazard_scoreboard. It contains the pending vector with set/clear ports and combinational pending lookups for three addresses.
- decode_stage holds the decode logic, operand mux, output register and HALTED flag.

## Test plan
- Back-to-back issue:
  - Stimulus: r3 = 3, r4 = 4; issue ADD r3,r4 then LDI r5,0x7F with ex_ready = 1.
  - Required: ex_valid on consecutive cycles with ex_a = 3, ex_b = 4, ex_we = 1, then ex_b = 0x007F.
- RAW stall:
  - Stimulus: ADDI r2,-1 followed by MOV r6,r2.
  - Required: ex_b = 0xFFFF for the ADDI; if_ready = 0 until the cycle after wb_valid with wb_addr = 2; then MOV issues.
- WAW and r0:
  - Stimulus: LDI r1,5 followed by LDI r1,6.
  - Required: the second LDI stalls until r1 is retired.
  - Stimulus: LDI r0,5 twice.
  - Required: never stalls.
- Back-pressure:
  - Stimulus: hold ex_ready = 0 for 4 cycles with a payload pending.
  - Required: ex_* stable and if_ready = 0 throughout; the payload is consumed on release.
- HALT then reset:
  - Stimulus: issue HALT, then NOP, then rst_n low for 1 cycle.
  - Required: halted = 1 and the NOP is not accepted; after reset, halted = 0, the scoreboard is empty and the NOP is accepted.
